// File: rtl/ama_riscv_retire_tracker.sv
// ama_riscv_retire_tracker
// Observer that carries per-instruction side-band metadata from execute to
// retirement. At retirement it merges the metadata with the retired
// instruction/PC, updates saturating event counters, and pushes a trace
// record into a first-word-fall-through FIFO drained via valid/ready.
// Optional feature macro: RETIRE_TRACKER_BP_EN (branch-predictor hit tracking).
module ama_riscv_retire_tracker #(
  parameter int STAGES     = 3,
  parameter int ARCH_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     stage_en,
  input  logic [STAGES-1:0]     stage_bubble,
  input  logic                  cap_valid,
  input  logic                  cap_branch,
  input  logic                  cap_taken,
  input  logic                  cap_bp_hit,
  input  logic                  cap_dmem_valid,
  input  logic [ARCH_WIDTH-1:0] cap_dmem_addr,
  input  logic [2:0]            cap_dmem_size,
  input  logic                  inst_retired,
  input  logic [INST_WIDTH-1:0] inst_ret,
  input  logic [ARCH_WIDTH-1:0] pc_ret,
  input  logic                  clr_cnt,
  output logic                  trc_valid,
  input  logic                  trc_ready,
  output logic [INST_WIDTH-1:0] trc_inst,
  output logic [ARCH_WIDTH-1:0] trc_pc,
  output logic [ARCH_WIDTH-1:0] trc_dmem_addr,
  output logic                  trc_branch,
  output logic                  trc_taken,
  output logic                  trc_bp_hit,
  output logic [3:0]            trc_dmem_size,
  output logic [CNT_WIDTH-1:0]  cnt_retired,
  output logic [CNT_WIDTH-1:0]  cnt_branch,
  output logic [CNT_WIDTH-1:0]  cnt_taken,
  output logic [CNT_WIDTH-1:0]  cnt_bp_hit,
  output logic [CNT_WIDTH-1:0]  cnt_load,
  output logic [CNT_WIDTH-1:0]  cnt_store,
  output logic [CNT_WIDTH-1:0]  cnt_drop,
  output logic                  trc_ovf,
  output logic                  meta_err
);

  // Metadata word: {valid, branch, taken, bp_hit, addr, size[3:0]}
  localparam int META_W = ARCH_WIDTH + 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Trace record drops the valid bit: {inst, pc, branch, taken, bp_hit, addr, size}
  localparam int REC_W  = INST_WIDTH + ARCH_WIDTH + META_W - 1;
  localparam int NCNT   = 7;
  localparam logic [META_W-1:0] BUBBLE_META = META_W'(8);

  genvar gi;

  // ---------------- capture ----------------
  logic              w_cap_bp;
  logic [META_W-1:0] w_cap_meta;

`ifdef RETIRE_TRACKER_BP_EN
  assign w_cap_bp = cap_bp_hit & cap_branch;
`else
  // Predictor hit is not tracked in this build; the port is kept and ignored.
  assign w_cap_bp = cap_bp_hit & 1'b0;
`endif

  assign w_cap_meta = cap_valid ?
      {1'b1, cap_branch, cap_taken & cap_branch, w_cap_bp,
       cap_dmem_addr & {ARCH_WIDTH{cap_dmem_valid}},
       cap_dmem_valid ? {1'b0, cap_dmem_size} : 4'd8} :
      BUBBLE_META;

  // ---------------- metadata pipeline ----------------
  logic [META_W-1:0] w_stage_q [STAGES];

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [META_W-1:0] r_meta;
      logic [META_W-1:0] w_up;
      if (gi == 0) begin : g_first
        assign w_up = w_cap_meta;
      end else begin : g_rest
        assign w_up = w_stage_q[gi-1];
      end
      // Stage register: load upstream, insert a bubble, or hold
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_meta <= BUBBLE_META;
        end else if (stage_en[gi]) begin
          r_meta <= stage_bubble[gi] ? BUBBLE_META : w_up;
        end
      end
      assign w_stage_q[gi] = r_meta;
    end
  endgenerate

  logic [META_W-1:0] w_last;
  logic              w_last_valid;
  logic              w_last_branch;
  logic              w_last_taken;
  logic              w_last_bp;
  logic [3:0]        w_last_size;

  assign w_last        = w_stage_q[STAGES-1];
  assign w_last_valid  = w_last[META_W-1];
  assign w_last_branch = w_last[META_W-2];
  assign w_last_taken  = w_last[META_W-3];
  assign w_last_bp     = w_last[META_W-4];
  assign w_last_size   = w_last[3:0];

  // ---------------- trace FIFO ----------------
  logic [REC_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;
  logic [META_W-2:0] w_head_meta;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && trc_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = inst_retired && (!w_full || w_pop);
  assign w_drop  = inst_retired && w_full && !w_pop;
  assign w_rec   = {inst_ret, pc_ret, w_last[META_W-2:0]};

  // Record storage (no reset: contents are qualified by the pointers)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_rec;
    end
  end

  // Read/write pointers with an extra wrap bit for full/empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Head record shows bubble defaults while empty so idle outputs are clean.
  assign w_head      = r_mem[r_rptr[PTR_W-1:0]];
  assign w_head_meta = w_empty ? BUBBLE_META[META_W-2:0] : w_head[META_W-2:0];

  assign trc_valid     = !w_empty;
  assign trc_inst      = w_empty ? '0 : w_head[REC_W-1 -: INST_WIDTH];
  assign trc_pc        = w_empty ? '0 : w_head[META_W-1 +: ARCH_WIDTH];
  assign trc_branch    = w_head_meta[META_W-2];
  assign trc_taken     = w_head_meta[META_W-3];
  assign trc_dmem_addr = w_head_meta[ARCH_WIDTH+3:4];
  assign trc_dmem_size = w_head_meta[3:0];
`ifdef RETIRE_TRACKER_BP_EN
  assign trc_bp_hit    = w_head_meta[META_W-4];
`else
  assign trc_bp_hit    = 1'b0;
`endif

  // ---------------- event counters ----------------
  logic [NCNT-1:0]      w_ev;
  logic [CNT_WIDTH-1:0] w_cnt [NCNT];

  assign w_ev[0] = inst_retired;
  assign w_ev[1] = inst_retired && w_last_branch;
  assign w_ev[2] = inst_retired && w_last_taken;
  assign w_ev[3] = inst_retired && w_last_bp;
  assign w_ev[4] = inst_retired && (w_last_size[3:2] == 2'b00);
  assign w_ev[5] = inst_retired && (w_last_size[3:2] == 2'b01);
  assign w_ev[6] = w_drop;

  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      // Saturating counter; clear has priority over a same-cycle event
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (clr_cnt) begin
          r_cnt <= '0;
        end else if (w_ev[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign cnt_retired = w_cnt[0];
  assign cnt_branch  = w_cnt[1];
  assign cnt_taken   = w_cnt[2];
  assign cnt_bp_hit  = w_cnt[3];
  assign cnt_load    = w_cnt[4];
  assign cnt_store   = w_cnt[5];
  assign cnt_drop    = w_cnt[6];

  // Sticky overflow and bubble-retirement flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trc_ovf  <= 1'b0;
      meta_err <= 1'b0;
    end else if (clr_cnt) begin
      trc_ovf  <= 1'b0;
      meta_err <= 1'b0;
    end else begin
      if (w_drop) trc_ovf <= 1'b1;
      if (inst_retired && !w_last_valid) meta_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_retire_tracker.sv
// Self-checking bench for ama_riscv_retire_tracker: directed scenarios then
// randomized traffic, compared every cycle against a queue-based model.
module tb_ama_riscv_retire_tracker;
  localparam int ST = 3;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int FD = 8;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [ST-1:0] stage_en, stage_bubble;
  logic          cap_valid, cap_branch, cap_taken, cap_bp_hit, cap_dmem_valid;
  logic [AW-1:0] cap_dmem_addr;
  logic [2:0]    cap_dmem_size;
  logic          inst_retired;
  logic [IW-1:0] inst_ret;
  logic [AW-1:0] pc_ret;
  logic          clr_cnt, trc_ready;
  logic          trc_valid, trc_branch, trc_taken, trc_bp_hit, trc_ovf, meta_err;
  logic [IW-1:0] trc_inst;
  logic [AW-1:0] trc_pc, trc_dmem_addr;
  logic [3:0]    trc_dmem_size;
  logic [CW-1:0] cnt_retired, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_drop;

  ama_riscv_retire_tracker #(
    .STAGES(ST), .ARCH_WIDTH(AW), .INST_WIDTH(IW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stage_en(stage_en), .stage_bubble(stage_bubble),
    .cap_valid(cap_valid), .cap_branch(cap_branch), .cap_taken(cap_taken),
    .cap_bp_hit(cap_bp_hit), .cap_dmem_valid(cap_dmem_valid),
    .cap_dmem_addr(cap_dmem_addr), .cap_dmem_size(cap_dmem_size),
    .inst_retired(inst_retired), .inst_ret(inst_ret), .pc_ret(pc_ret),
    .clr_cnt(clr_cnt), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_inst(trc_inst), .trc_pc(trc_pc), .trc_dmem_addr(trc_dmem_addr),
    .trc_branch(trc_branch), .trc_taken(trc_taken), .trc_bp_hit(trc_bp_hit),
    .trc_dmem_size(trc_dmem_size), .cnt_retired(cnt_retired), .cnt_branch(cnt_branch),
    .cnt_taken(cnt_taken), .cnt_bp_hit(cnt_bp_hit), .cnt_load(cnt_load),
    .cnt_store(cnt_store), .cnt_drop(cnt_drop), .trc_ovf(trc_ovf), .meta_err(meta_err)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          v, br, tk, bp;
    logic [AW-1:0] addr;
    logic [3:0]    sz;
  } meta_t;
  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
    meta_t         m;
  } rec_t;

  meta_t m_st [ST];
  rec_t  m_q [$];
  int    m_cnt [7];   // retired, branch, taken, bp_hit, load, store, drop
  bit    m_ovf, m_merr;

  int checks = 0;
  int failures = 0;

  function automatic meta_t bubble();
    meta_t b;
    b = '0;
    b.sz = 4'd8;
    return b;
  endfunction

  function automatic int sat_inc(int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ST; k++) m_st[k] = bubble();
    m_q.delete();
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    m_ovf = 0;
    m_merr = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    meta_t cap;
    meta_t nst [ST];
    rec_t  r;
    bit    pop;
    cap = bubble();
    if (cap_valid) begin
      cap.v  = 1'b1;
      cap.br = cap_branch;
      cap.tk = cap_taken && cap_branch;
`ifdef RETIRE_TRACKER_BP_EN
      cap.bp = cap_bp_hit && cap_branch;
`else
      cap.bp = 1'b0;
`endif
      cap.addr = cap_dmem_valid ? cap_dmem_addr : '0;
      cap.sz   = cap_dmem_valid ? {1'b0, cap_dmem_size} : 4'd8;
    end
    pop = (m_q.size() != 0) && trc_ready;
    if (pop) void'(m_q.pop_front());
    if (inst_retired) begin
      r.inst = inst_ret;
      r.pc   = pc_ret;
      r.m    = m_st[ST-1];
      if (!r.m.v) m_merr = 1;
      m_cnt[0] = sat_inc(m_cnt[0]);
      if (r.m.br) m_cnt[1] = sat_inc(m_cnt[1]);
      if (r.m.tk) m_cnt[2] = sat_inc(m_cnt[2]);
      if (r.m.bp) m_cnt[3] = sat_inc(m_cnt[3]);
      if (r.m.sz < 4) m_cnt[4] = sat_inc(m_cnt[4]);
      else if (r.m.sz < 8) m_cnt[5] = sat_inc(m_cnt[5]);
      if (m_q.size() >= FD) begin
        m_cnt[6] = sat_inc(m_cnt[6]);
        m_ovf = 1;
      end else begin
        m_q.push_back(r);
      end
    end
    if (clr_cnt) begin
      for (int i = 0; i < 7; i++) m_cnt[i] = 0;
      m_ovf = 0;
      m_merr = 0;
    end
    for (int k = 0; k < ST; k++) begin
      if (!stage_en[k])         nst[k] = m_st[k];
      else if (stage_bubble[k]) nst[k] = bubble();
      else                      nst[k] = (k == 0) ? cap : m_st[k-1];
    end
    for (int k = 0; k < ST; k++) m_st[k] = nst[k];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("trc_valid", 64'(trc_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("trc_inst", 64'(trc_inst), 64'(m_q[0].inst));
      chk("trc_pc", 64'(trc_pc), 64'(m_q[0].pc));
      chk("trc_dmem_addr", 64'(trc_dmem_addr), 64'(m_q[0].m.addr));
      chk("trc_dmem_size", 64'(trc_dmem_size), 64'(m_q[0].m.sz));
      chk("trc_branch", 64'(trc_branch), 64'(m_q[0].m.br));
      chk("trc_taken", 64'(trc_taken), 64'(m_q[0].m.tk));
      chk("trc_bp_hit", 64'(trc_bp_hit), 64'(m_q[0].m.bp));
    end
    chk("cnt_retired", 64'(cnt_retired), 64'(m_cnt[0]));
    chk("cnt_branch", 64'(cnt_branch), 64'(m_cnt[1]));
    chk("cnt_taken", 64'(cnt_taken), 64'(m_cnt[2]));
    chk("cnt_bp_hit", 64'(cnt_bp_hit), 64'(m_cnt[3]));
    chk("cnt_load", 64'(cnt_load), 64'(m_cnt[4]));
    chk("cnt_store", 64'(cnt_store), 64'(m_cnt[5]));
    chk("cnt_drop", 64'(cnt_drop), 64'(m_cnt[6]));
    chk("trc_ovf", 64'(trc_ovf), 64'(m_ovf));
    chk("meta_err", 64'(meta_err), 64'(m_merr));
  endtask

  // One clock: model advances on the applied inputs, DUT sampled 1 after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    stage_en = '1; stage_bubble = '0;
    cap_valid = 0; cap_branch = 0; cap_taken = 0; cap_bp_hit = 0;
    cap_dmem_valid = 0; cap_dmem_addr = '0; cap_dmem_size = '0;
    inst_retired = 0; inst_ret = '0; pc_ret = '0;
    clr_cnt = 0; trc_ready = 0;
  endtask

  task automatic set_retire();
    inst_retired = 1;
    inst_ret = $urandom;
    pc_ret = $urandom;
  endtask

  // Step until the last stage holds a real instruction (bounded).
  task automatic wait_last_valid();
    int n = 0;
    while (!m_st[ST-1].v && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!m_st[ST-1].v) begin
      failures++;
      $display("FAIL wait_last_valid observed=timeout required=arrival within 20 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    trc_ready = 1;
    while (m_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    trc_ready = 0;
    chk("drain_empty", 64'(trc_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_trc_size", 64'(trc_dmem_size), 64'd8);
    chk("rst_trc_inst", 64'(trc_inst), 64'd0);
    rst = 1;
    step();

    // Taken branch through three stages, then retire.
    cap_valid = 1; cap_branch = 1; cap_taken = 1;
    step();
    idle();
    wait_last_valid();
    set_retire();
    step();
    idle();
    chk("A_branch", 64'(trc_branch), 64'd1);
    chk("A_taken", 64'(trc_taken), 64'd1);
    chk("A_cnt_branch", 64'(cnt_branch), 64'd1);
    chk("A_cnt_taken", 64'(cnt_taken), 64'd1);
    drain();

    // sw to 0x100, upstream frozen 4 cycles while bubbles flow out of stage 2.
    cap_valid = 1; cap_dmem_valid = 1; cap_dmem_addr = 32'h100; cap_dmem_size = 3'd6;
    step();
    idle();
    stage_en = 3'b100; stage_bubble = 3'b100;
    repeat (4) step();
    idle();
    wait_last_valid();
    set_retire();
    step();
    idle();
    chk("B_addr", 64'(trc_dmem_addr), 64'h100);
    chk("B_size", 64'(trc_dmem_size), 64'd6);
    chk("B_cnt_store", 64'(cnt_store), 64'd1);
    repeat (4) step();
    chk("B_no_dup", 64'(cnt_retired), 64'd2);
    drain();

    // Bubble injected into last stage, retire the next cycle.
    cap_valid = 1;
    step();
    idle();
    step();
    stage_bubble = 3'b100;
    step();
    idle();
    set_retire();
    step();
    idle();
    chk("C_meta_err", 64'(meta_err), 64'd1);
    chk("C_size", 64'(trc_dmem_size), 64'd8);
    drain();

    // Overflow: 10 retirements into an 8-entry FIFO with no drain.
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_retire();
      step();
    end
    chk("D_cnt_drop", 64'(cnt_drop), 64'd2);
    chk("D_ovf", 64'(trc_ovf), 64'd1);
    chk("D_cnt_retired", 64'(cnt_retired), 64'd10);
    set_retire();
    trc_ready = 1;
    step();
    chk("D_full_push_pop", 64'(cnt_drop), 64'd2);
    idle();
    drain();

    // Counter saturation, then clear with a simultaneous retirement.
    trc_ready = 1;
    for (int i = 0; i < CMAX + 6; i++) begin
      set_retire();
      step();
    end
    chk("E_saturate", 64'(cnt_retired), 64'(CMAX));
    set_retire();
    clr_cnt = 1;
    step();
    idle();
    chk("E_clr_wins", 64'(cnt_retired), 64'd0);
    drain();

    // Predictor hit on a branch.
    cap_valid = 1; cap_branch = 1; cap_bp_hit = 1;
    step();
    idle();
    wait_last_valid();
    set_retire();
    step();
    idle();
`ifdef RETIRE_TRACKER_BP_EN
    chk("F_trc_bp_hit", 64'(trc_bp_hit), 64'd1);
    chk("F_cnt_bp_hit", 64'(cnt_bp_hit), 64'd1);
`else
    chk("F_trc_bp_hit", 64'(trc_bp_hit), 64'd0);
    chk("F_cnt_bp_hit", 64'(cnt_bp_hit), 64'd0);
`endif
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < ST; k++) begin
        stage_en[k]     = ($urandom_range(0, 3) != 0);
        stage_bubble[k] = ($urandom_range(0, 7) == 0);
      end
      cap_valid      = $urandom_range(0, 1);
      cap_branch     = $urandom_range(0, 1);
      cap_taken      = $urandom_range(0, 1);
      cap_bp_hit     = $urandom_range(0, 1);
      cap_dmem_valid = $urandom_range(0, 1);
      cap_dmem_addr  = $urandom;
      cap_dmem_size  = 3'($urandom_range(0, 7));
      inst_retired   = $urandom_range(0, 1);
      inst_ret       = $urandom;
      pc_ret         = $urandom;
      trc_ready      = ($urandom_range(0, 2) == 0);
      clr_cnt        = ($urandom_range(0, 29) == 0);
      step();
    end
    idle();

    // Reset asserted mid-operation with records queued.
    for (int i = 0; i < 3; i++) begin
      set_retire();
      step();
    end
    idle();
    chk("H_pre_valid", 64'(trc_valid), 64'd1);
    rst = 0;
    #1;
    model_reset();
    check_all();
    chk("H_rst_size", 64'(trc_dmem_size), 64'd8);
    rst = 1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ama_riscv_retire_tracker.md
# ama_riscv_retire_tracker

Parametrised retirement tracker that carries per-instruction side-band metadata (branch, taken, predictor hit, data-memory address and size) from the execute stage through a configurable number of pipeline registers to retirement. At retirement it merges the metadata with the retired instruction and PC, keeps saturating event counters, and pushes a trace record into a FIFO with a valid/ready drain port. It is a verification-side observer bound alongside the core and has no effect on core behaviour.

## Interface
- `STAGES`, 3, register stages between execute capture and retirement (≥1)
- `ARCH_WIDTH`, 32, PC and address width
- `INST_WIDTH`, 32, instruction width
- `FIFO_DEPTH`, 8, trace FIFO entries (power of 2, ≥2)
- `CNT_WIDTH`, 32, event counter width

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stage_en`  in  STAGES  per-stage load enable (bit 0 = exe→next)
- `stage_bubble`  in  STAGES  load a bubble instead of upstream data (effective only with matching `stage_en`)
- `cap_valid`  in  1  execute stage holds a real instruction
- `cap_branch`, `cap_taken`, `cap_bp_hit`  in  1 each  branch attributes at execute
- `cap_dmem_valid`  in  1  data-memory request issued
- `cap_dmem_addr`  in  ARCH_WIDTH  request address
- `cap_dmem_size`  in  3  {store, size[1:0]}: 0–3 lb..ld, 4–7 sb..sd
- `inst_retired`  in  1  retirement strobe
- `inst_ret`  in  INST_WIDTH, `pc_ret`  in  ARCH_WIDTH  retiring instruction and PC
- `clr_cnt`  in  1  synchronous clear of counters and sticky flags
- `trc_valid`  out  1, `trc_ready`  in  1  trace drain handshake
- `trc_inst`, `trc_pc`, `trc_dmem_addr`  out  as above  head record
- `trc_branch`, `trc_taken`, `trc_bp_hit`  out  1 each
- `trc_dmem_size`  out  4  0–7 as capture, 8 = no access
- `cnt_retired`, `cnt_branch`, `cnt_taken`, `cnt_bp_hit`, `cnt_load`, `cnt_store`, `cnt_drop`  out  CNT_WIDTH each
- `trc_ovf`  out  1  sticky: a record was dropped
- `meta_err`  out  1  sticky: retirement with bubble metadata

## Operation
- Stage 0 input: {valid=`cap_valid`, branch, taken=`cap_taken`&`cap_branch`, bp_hit=`cap_bp_hit`&`cap_branch`, addr=`cap_dmem_addr` masked by `cap_dmem_valid`, size=`cap_dmem_valid` ? {0,`cap_dmem_size`} : 8}; invalid capture forces all fields to bubble.
- Stage k loads stage k−1 when `stage_en[k]`; loads bubble (valid 0, flags 0, addr 0, size 8) when `stage_en[k]`&`stage_bubble[k]`; holds otherwise.
- On `inst_retired`: record = {`inst_ret`, `pc_ret`, last-stage metadata}. If last-stage valid=0, set `meta_err` and push record with bubble metadata.
- Counters increment on `inst_retired`: retired always; branch/taken/bp_hit per record flag; load if size 0–3; store if 4–7. Saturate at all-ones.
- FIFO push on `inst_retired`; pop on `trc_valid`&`trc_ready`. Full and no pop: record dropped, `cnt_drop`++, `trc_ovf` set. Full with pop: push accepted. Empty: pop ignored.
- Pointers wrap modulo FIFO_DEPTH; extra occupancy bit distinguishes full/empty.
- `clr_cnt` zeroes counters, `trc_ovf`, `meta_err`; same-cycle events are not counted (clear wins). FIFO contents unaffected.

## Timing
- Reset: all stages bubble, FIFO empty, `trc_valid`=0, trace outputs 0 except `trc_dmem_size`=8, counters 0, flags 0.
- With `stage_en` all high, metadata captured at edge t is in the last stage after edge t+STAGES−1 and pairs with `inst_retired` in that cycle.
- Push at retirement edge; `trc_valid` high and head data valid the following cycle (first-word fall-through). Counters update at the same edge.
- `trc_*` data stable while `trc_valid`&!`trc_ready`.
- Reset assertion mid-operation discards FIFO contents and in-flight metadata immediately.

## Configuration
- `RETIRE_TRACKER_BP_EN` defined: `cap_bp_hit` tracked, `trc_bp_hit` and `cnt_bp_hit` live.
- Not defined: no bp_hit storage; `trc_bp_hit`=0, `cnt_bp_hit`=0; port retained and ignored.

## Test plan
- STAGES=3, enables high, taken branch at exe cycle 10 with retire at cycle 12 -> record branch=1, taken=1; `cnt_branch`=`cnt_taken`=1.
- Store sw to 0x100 then stall `stage_en[1]` 4 cycles -> record addr=0x100, size=6, `cnt_store`=1; no duplication during stall.
- `stage_bubble[2]` with retire next cycle -> `meta_err`=1, record size=8.
- FIFO_DEPTH=8, `trc_ready`=0, 10 retirements -> 8 records, `cnt_drop`=2, `trc_ovf`=1; then drain preserves order; full+push+pop same cycle -> no drop.
- Force `cnt_retired` to all-ones, retire -> stays all-ones; `clr_cnt` with retire -> 0.
- Without `RETIRE_TRACKER_BP_EN`, `cap_bp_hit`=1 on branch -> `trc_bp_hit`=0, `cnt_bp_hit`=0.
